// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and frame-size helpers for the scan generator.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_PIPE     = 1;

  // Coordinate width and the largest line/frame length it can represent.
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1024;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/pix_delay_line.sv
// Enable-gated shift register used to keep control signals aligned with delayed pixel data.
module pix_delay_line #(
  parameter int unsigned          WIDTH   = 1,
  parameter int unsigned          DEPTH   = 1,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    // Zero depth: straight wire, clock/reset/enable intentionally unused.
    logic unused_ctl;
    assign unused_ctl = clk ^ rst_n ^ en;
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per enabled cycle; reset loads the inactive level everywhere.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan timing generator: pixel-rate strobe, coordinates, sync/blank decode and matched-delay controls.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned PIPE     = DEF_PIPE
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] ptx,
  output logic [CNT_W-1:0] pty,
  output logic             pix_en,
  output logic             active,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             frame_start,
  output logic             active_d,
  output logic             hsync_n_d,
  output logic             vsync_n_d
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CMP_W   = CNT_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  // One extra bit so a window ending exactly at 1024 still compares correctly.
  localparam logic [CMP_W-1:0] H_VIS_END = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0] V_VIS_END = CMP_W'(V_ACTIVE);
  localparam logic [CMP_W-1:0] HS_BEG    = CMP_W'(H_ACTIVE + H_FP);
  localparam logic [CMP_W-1:0] HS_END    = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] VS_BEG    = CMP_W'(V_ACTIVE + V_FP);
  localparam logic [CMP_W-1:0] VS_END    = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
    $error("vga_scan_gen: H_TOTAL/V_TOTAL exceed 10-bit coordinate range");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_scan_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div;
  logic             div_wrap;
  logic [CNT_W-1:0] hcnt, vcnt, hcnt_nx, vcnt_nx;
  logic [CMP_W-1:0] hx, vx;
  logic             h_wrap;
  logic             active_nx, hsync_n_nx, vsync_n_nx, frame_start_nx;
  logic [2:0]       dly_q;

  // Next raster position and the control decode of that position.
  always_comb begin
    div_wrap       = (div == DIV_LAST);
    h_wrap         = (hcnt == H_LAST);
    hcnt_nx        = h_wrap ? '0 : hcnt + CNT_W'(1);
    vcnt_nx        = vcnt;
    if (h_wrap) vcnt_nx = (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
    hx             = {1'b0, hcnt_nx};
    vx             = {1'b0, vcnt_nx};
    active_nx      = (hx < H_VIS_END) && (vx < V_VIS_END);
    hsync_n_nx     = !((hx >= HS_BEG) && (hx < HS_END));
    vsync_n_nx     = !((vx >= VS_BEG) && (vx < VS_END));
    frame_start_nx = (hcnt_nx == '0) && (vcnt_nx == '0);
  end

  // Clock divider, raster counters and registered controls, advanced once per pixel strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div         <= '0;
      pix_en      <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      active      <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div    <= div_wrap ? '0 : div + DIV_W'(1);
      pix_en <= div_wrap;
      if (pix_en) begin
        hcnt        <= hcnt_nx;
        vcnt        <= vcnt_nx;
        active      <= active_nx;
        hsync_n     <= hsync_n_nx;
        vsync_n     <= vsync_n_nx;
        frame_start <= frame_start_nx;
      end
    end
  end

  assign ptx = hcnt;
  assign pty = vcnt;

  // Controls delayed by PIPE pixel ticks to line up with downstream colour stages.
  pix_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PIPE),
    .RST_VAL(3'b011)
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pix_en),
    .din  ({active, hsync_n, vsync_n}),
    .dout (dly_q)
  );

  assign active_d  = dly_q[2];
  assign hsync_n_d = dly_q[1];
  assign vsync_n_d = dly_q[0];

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench: three generator configurations checked against a frame-index reference model.
module tb_vga_scan_gen;

  localparam int NI = 3;
  // Config 0: full 640x480 timing; configs 1-2: tiny rasters so frame wraps occur often.
  localparam int HA [NI] = '{640, 8, 5};
  localparam int HF [NI] = '{16, 2, 1};
  localparam int HS [NI] = '{96, 3, 2};
  localparam int HB [NI] = '{48, 2, 1};
  localparam int VA [NI] = '{480, 4, 3};
  localparam int VF [NI] = '{10, 1, 2};
  localparam int VS [NI] = '{2, 2, 1};
  localparam int VB [NI] = '{33, 1, 2};
  localparam int DV [NI] = '{2, 1, 3};
  localparam int PP [NI] = '{1, 2, 0};

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic act, hs, vs, fs, ad, hd, vd;
  } obs_t;

  localparam obs_t RST_OBS = '{x: 10'd0, y: 10'd0, act: 1'b0, hs: 1'b1, vs: 1'b1,
                               fs: 1'b0, ad: 1'b0, hd: 1'b1, vd: 1'b1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] ptx [NI];
  logic [9:0] pty [NI];
  logic       pix_en [NI], active [NI], hsync_n [NI], vsync_n [NI], frame_start [NI];
  logic       active_d [NI], hsync_n_d [NI], vsync_n_d [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_scan_gen #(
      .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
      .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
      .CLK_DIV(DV[g]), .PIPE(PP[g])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ptx        (ptx[g]),
      .pty        (pty[g]),
      .pix_en     (pix_en[g]),
      .active     (active[g]),
      .hsync_n    (hsync_n[g]),
      .vsync_n    (vsync_n[g]),
      .frame_start(frame_start[g]),
      .active_d   (active_d[g]),
      .hsync_n_d  (hsync_n_d[g]),
      .vsync_n_d  (vsync_n_d[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic int htot(input int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vtot(input int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction

  // {active, hsync_n, vsync_n} presented after the k-th pixel load (k<=0: nothing loaded yet).
  function automatic logic [2:0] ctrl_at(input int i, input int k);
    int n, x, y;
    logic a, h, v;
    if (k <= 0) return 3'b011;
    n = k % (htot(i) * vtot(i));
    x = n % htot(i);
    y = n / htot(i);
    a = (x < HA[i]) && (y < VA[i]);
    h = !((x >= HA[i] + HF[i]) && (x < HA[i] + HF[i] + HS[i]));
    v = !((y >= VA[i] + VF[i]) && (y < VA[i] + VF[i] + VS[i]));
    return {a, h, v};
  endfunction

  // After the k-th load the raster sits at linear index k (mod frame size).
  function automatic obs_t expect_load(input int i, input int k);
    obs_t e;
    int n;
    logic [2:0] c, cd;
    n  = k % (htot(i) * vtot(i));
    c  = ctrl_at(i, k);
    cd = ctrl_at(i, k - PP[i]);
    e.x  = 10'(n % htot(i));
    e.y  = 10'(n / htot(i));
    e.act = c[2];
    e.hs  = c[1];
    e.vs  = c[0];
    e.fs  = (n == 0);
    e.ad  = cd[2];
    e.hd  = cd[1];
    e.vd  = cd[0];
    return e;
  endfunction

  // ---------------- scoreboard queues ----------------
  obs_t q0[$], q1[$], q2[$];

  function automatic void sb_push(input int i, input obs_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic obs_t sb_pop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int sb_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void sb_clear(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%h exp=%h", nm, i, $time, got, exp);
    end
  endtask

  // ---------------- model side: runs on every clock edge ----------------
  int   cyc [NI];
  logic exp_rst [NI];
  logic exp_pe [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        cyc[i]     = 0;
        exp_rst[i] = 1'b1;
        exp_pe[i]  = 1'b0;
      end else begin
        cyc[i]     = cyc[i] + 1;
        exp_rst[i] = 1'b0;
        exp_pe[i]  = (cyc[i] % DV[i] == 0);
        if (cyc[i] >= 2 && ((cyc[i] - 1) % DV[i] == 0))
          sb_push(i, expect_load(i, (cyc[i] - 1) / DV[i]));
      end
    end
  end

  // ---------------- monitor: samples mid-cycle ----------------
  logic pe_prev [NI];
  obs_t last_exp [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      obs_t o;
      o = '{x: ptx[i], y: pty[i], act: active[i], hs: hsync_n[i], vs: vsync_n[i],
            fs: frame_start[i], ad: active_d[i], hd: hsync_n_d[i], vd: vsync_n_d[i]};
      if (exp_rst[i]) begin
        last_exp[i] = RST_OBS;
        chk("reset_state", i, 64'({pix_en[i], o}), 64'({1'b0, RST_OBS}));
      end else begin
        chk("pix_en", i, 64'(pix_en[i]), 64'(exp_pe[i]));
        if (pe_prev[i]) begin
          if (sb_size(i) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_update dut%0d t=%0t got=update exp=hold", i, $time);
          end else begin
            last_exp[i] = sb_pop(i);
          end
        end
        chk("outputs", i, 64'(o), 64'(last_exp[i]));
        if (sb_size(i) != 0) begin
          checks++;
          errors++;
          $display("FAIL missing_update dut%0d t=%0t got=hold exp=update", i, $time);
          sb_clear(i);
        end
      end
      pe_prev[i] = pix_en[i];
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NI; i++) begin
      cyc[i]      = 0;
      exp_rst[i]  = 1'b0;
      exp_pe[i]   = 1'b0;
      pe_prev[i]  = 1'b0;
      last_exp[i] = RST_OBS;
    end
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    // Long first run covers all of line 0 of the full-size raster, including the hsync window.
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    // Random mid-frame resets and run lengths.
    for (int r = 0; r < 8; r++) begin
      rst_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_n = 1'b1;
      repeat ($urandom_range(200, 3000)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
Pixel-scan timing generator that sits directly upstream of insideT. It produces the 10-bit raster coordinate (ptx, pty) for every pixel of a 640x480@60 frame, plus sync and blanking controls. Sync and active outputs are also provided through a matched-delay path, so they stay aligned with colour computed by downstream combinational and pipelined stages.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel (>=1)
PIPE, 1, pixel-tick delay applied to the *_d outputs (>=0)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ptx  out  10  current pixel x (horizontal count)
pty  out  10  current pixel y (vertical count)
pix_en  out  1  one-clk strobe; ptx/pty/ctrl updated on the following edge
active  out  1  coordinate is in the visible area
hsync_n  out  1  horizontal sync, active low
vsync_n  out  1  vertical sync, active low
frame_start  out  1  one-pixel-period flag: coordinate is (0,0)
active_d  out  1  active delayed PIPE pixel ticks
hsync_n_d  out  1  hsync_n delayed PIPE pixel ticks
vsync_n_d  out  1  vsync_n delayed PIPE pixel ticks

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be <= 1024; an elaboration-time check fails otherwise.
- Reset (rst_n=0 at a clk edge), values on the following edge:
  - div, hcnt, vcnt = 0
  - ptx, pty = 0
  - pix_en = 0, active = 0, frame_start = 0
  - hsync_n = 1, vsync_n = 1
  - all *_d outputs = inactive (active_d = 0, syncs = 1)
  - Reset mid-frame behaves identically: no partial-line recovery.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = (div == CLK_DIV-1) as a registered strobe. With CLK_DIV=1, pix_en stays high every cycle after the first post-reset cycle.
- Counters advance only on cycles where pix_en=1:
  - hcnt increments; when hcnt == H_TOTAL-1 it wraps to 0 and vcnt increments.
  - When vcnt == V_TOTAL-1 at the same time as the h-wrap, vcnt wraps to 0.
  - No saturation; simultaneous h- and v-wrap happen on the same edge.
- Output registers are loaded on every pix_en edge from the new counter values:
  - ptx = hcnt, pty = vcnt
  - active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE)
  - hsync_n = !(H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC), i.e. low for hcnt 656..751
  - vsync_n = !(V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC), i.e. low for vcnt 490..491
  - frame_start = (hcnt == 0 && vcnt == 0)
  - Outputs hold their value between pix_en edges.
- First post-reset pixel: counters start at 0, and the first pix_en load presents (1,0). Pixel (0,0) with frame_start is first presented after one full frame. This is intentional, keeps the logic uniform, and the bench must expect it.
- Delay path:
  - *_d outputs are PIPE-stage shift registers clocked only on pix_en, reset to inactive levels.
  - PIPE=0: *_d equal the undelayed outputs exactly.
- ptx and pty are not clamped outside the active area; downstream logic gates on active.

Decomposition:
- vga_timing_pkg: default timing constants for 640x480@60, plus helper functions h_total() and v_total().
- One sub-module, pix_delay_line: parameterised width/depth shift register with enable and sync reset value, instanced once at width 3 for {active, hsync_n, vsync_n}.
- Counters and decode stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 5 clks -> ptx=0, pty=0, hsync_n=1, vsync_n=1, active=0, pix_en=0, all *_d inactive.
- CLK_DIV=2 cadence: release reset -> pix_en high on every 2nd clk; ptx steps 1,2,3 on successive pix_en; active=1 while pty=0 and ptx<640.
- Hsync window: scan line 0 -> hsync_n low exactly when ptx=656..751 (96 ticks), high at ptx=655 and 752; active=0 for ptx>=640.
- Line and frame wrap: at ptx=799, pty=524 the next tick gives ptx=0, pty=0, frame_start=1 for one tick; vsync_n low only for pty=490..491.
- Reset mid-frame: assert rst_n=0 at ptx=300, pty=200 for 1 clk -> next edge all outputs at reset values; counting restarts from 0.
- PIPE=2: the active_d/hsync_n_d/vsync_n_d edges lag their undelayed counterparts by exactly 2 pix_en ticks. PIPE=0: they are identical every cycle.
